// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit seven-segment scan controller with frame-synchronous load
//
// Purpose: time-multiplexes six 4-bit digit codes onto a shared segment bus,
// one digit enable at a time, with an optional blank guard between digits.
// New contents arrive through a valid/ready handshake into a one-entry pending
// buffer and are copied into the displayed shadow only at frame boundaries.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_digits     six digit codes, [3:0] = digit 0 ... [23:20] = digit 5
//   i_dp         decimal-point request per digit
//   i_load       load valid
//   o_load_rdy   pending buffer empty, load can be accepted
//   o_seg_enb    one-hot digit enable, active-high
//   o_seg        segments {g,f,e,d,c,b,a}, active-high
//   o_seg_dp     decimal point, active-high
//   o_frame_done one-cycle pulse on the first cycle of each new frame
//
// Configuration macro: SEG_SCAN_HEX_EN - codes 0xA..0xF show hex glyphs;
// when undefined they decode to a blank digit.

module seg_scan_ctrl #(
  parameter int unsigned DWELL_CYC = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic        i_load,
  output logic        o_load_rdy,
  output logic [5:0]  o_seg_enb,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic        o_frame_done
);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  // cnt holds the number of cycles already spent in the current state; the
  // value 0 only occurs right after reset so the first digit gets a full dwell.
  logic [31:0] cnt, cnt_nxt;
  logic        boundary;

  logic [23:0] shadow_digits, shadow_digits_nxt;
  logic [5:0]  shadow_dp, shadow_dp_nxt;
  logic [23:0] pend_digits;
  logic [5:0]  pend_dp;
  logic        accept;
  logic [3:0]  dig_sel;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
`ifdef SEG_SCAN_HEX_EN
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      4'hF: g = 7'b1110001;
`else
      // Blank glyph lets the upstream logic suppress leading zeros.
      default: g = 7'b0000000;
`endif
    endcase
    return g;
  endfunction

  assign accept = i_load & o_load_rdy;

  // Next-state logic. Outputs are registered from the next state so that
  // the output bus and the FSM state always describe the same cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 32'd1;
    boundary  = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == DWELL_CYC) begin
          cnt_nxt = 32'd1;
          if (BLANK_CYC == 0) begin
            state_nxt = SHOW;
            idx_nxt   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            boundary  = (idx == 3'd5);
          end else begin
            state_nxt = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt == BLANK_CYC) begin
          state_nxt = SHOW;
          cnt_nxt   = 32'd1;
          idx_nxt   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
          boundary  = (idx == 3'd5);
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  // At a boundary a full pending buffer wins; with the buffer empty, a load
  // arriving on the boundary edge itself bypasses straight into the shadow.
  always_comb begin
    shadow_digits_nxt = shadow_digits;
    shadow_dp_nxt     = shadow_dp;
    if (boundary) begin
      if (!o_load_rdy) begin
        shadow_digits_nxt = pend_digits;
        shadow_dp_nxt     = pend_dp;
      end else if (accept) begin
        shadow_digits_nxt = i_digits;
        shadow_dp_nxt     = i_dp;
      end
    end
  end

  always_comb begin
    case (idx_nxt)
      3'd0:    dig_sel = shadow_digits_nxt[3:0];
      3'd1:    dig_sel = shadow_digits_nxt[7:4];
      3'd2:    dig_sel = shadow_digits_nxt[11:8];
      3'd3:    dig_sel = shadow_digits_nxt[15:12];
      3'd4:    dig_sel = shadow_digits_nxt[19:16];
      3'd5:    dig_sel = shadow_digits_nxt[23:20];
      default: dig_sel = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SHOW;
      idx           <= 3'd0;
      cnt           <= 32'd0;
      shadow_digits <= 24'h0;
      shadow_dp     <= 6'h0;
      pend_digits   <= 24'h0;
      pend_dp       <= 6'h0;
      o_load_rdy    <= 1'b1;
      o_seg_enb     <= 6'h0;
      o_seg         <= 7'h0;
      o_seg_dp      <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      shadow_digits <= shadow_digits_nxt;
      shadow_dp     <= shadow_dp_nxt;
      o_frame_done  <= boundary;
      if (accept && !boundary) begin
        pend_digits <= i_digits;
        pend_dp     <= i_dp;
        o_load_rdy  <= 1'b0;
      end else if (boundary && !o_load_rdy) begin
        o_load_rdy  <= 1'b1;
      end
      if (state_nxt == SHOW) begin
        o_seg_enb <= 6'b000001 << idx_nxt;
        o_seg     <= decode(dig_sel);
        o_seg_dp  <= shadow_dp_nxt[idx_nxt];
      end else begin
        o_seg_enb <= 6'h0;
        o_seg     <= 7'h0;
        o_seg_dp  <= 1'b0;
      end
    end
  end

endmodule
